// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package adder;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the datapath of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes an operand pair LSB first,
// taking WIDTH cycles per job, with valid/ready handshakes on both sides.
module serial_adder
    import adder::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, out_valid_q, busy_q;
    logic             sum_s, carry_s;

    full_adder u_cell (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {sum_s, res_q[WIDTH-1:1]};
                carry_d = carry_s;
                // Counter parks on its last value so it never wraps inside a job.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and handshake-output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            cnt_q       <= {CW{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d == RUN);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = res_q;
    assign cout      = carry_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: op_a/op_b/cin are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block accepts a new operand set.
REQ-006 The block SHALL have ports op_a and op_b, input, WIDTH bits each: addends.
REQ-007 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result/cout are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port result, output, WIDTH bits: sum of op_a + op_b + cin, modulo 2^WIDTH.
REQ-011 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1.
REQ-012 The block SHALL have port busy, output, 1 bit: high in RUN state.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 The block SHALL drive in_ready = 1 only in IDLE and out_valid = 1 only in DONE, with no combinational path from inputs to these outputs.
REQ-015 On an IDLE edge with in_valid=1, the block SHALL capture op_a and op_b into shift registers, load the carry flop with cin, clear the bit counter to 0, and enter RUN.
REQ-016 While in IDLE with in_valid=0, the block SHALL hold all state.
REQ-017 On each RUN edge, the block SHALL present the operand LSBs and the carry flop to one full-adder bit cell.
REQ-018 On each RUN edge, the block SHALL shift the cell's sum into result from the MSB end (right shift) and shift both operand registers right by 1.
REQ-019 On each RUN edge, the block SHALL load the carry flop with the cell's carry and increment the counter.
REQ-020 On the RUN edge where the counter equals WIDTH-1, the block SHALL complete the last bit and enter DONE.
REQ-021 Latency SHALL be exactly WIDTH cycles: out_valid asserts WIDTH rising edges after the accepting edge.
REQ-022 In DONE, result and cout (cout = the carry flop) SHALL hold stable until out_ready=1 is sampled, then the block SHALL return to IDLE on that edge.
REQ-023 The block SHALL spend at least one IDLE cycle between jobs, giving a throughput of one addition per WIDTH+2 cycles at best.
REQ-024 in_valid SHALL be ignored in RUN and DONE; operand changes during RUN SHALL NOT affect the result.
REQ-025 out_ready SHALL be ignored outside DONE.
REQ-026 The counter SHALL be $clog2(WIDTH) bits wide (minimum 1 bit) and SHALL NOT wrap within a job.
REQ-027 On an all-ones + 1 overflow, result SHALL wrap to 0 with cout=1.

Reset
REQ-028 When rst_n=0 is sampled on a clk edge, the block SHALL enter IDLE and clear the operand registers, result, carry flop and counter.
REQ-029 After reset, the outputs SHALL be: in_ready=1, out_valid=0, busy=0, result=0, cout=0.
REQ-030 Reset SHALL take priority over every other event, including mid-RUN and DONE-with-out_ready.
REQ-031 A job interrupted by reset SHALL be discarded with no out_valid pulse.

Structure
REQ-032 The state enum typedef (IDLE/RUN/DONE) and the default width constant SHALL live in the shared package adder, imported by serial_adder and the bench.
REQ-033 The bit cell SHALL be the existing full_adder module (ports a, b, c, sum, carry), instantiated exactly once; serial_adder SHALL NOT contain a separate combinational adder.
REQ-034 The bench SHALL drive the block through an interface holding all ports, with a class-based test in the same style as the existing adder bench.

Verification (WIDTH=8)
REQ-035 Accept 8'h03 + 8'h05, cin=0 -> out_valid 8 cycles later with result=8'h08 and cout=0.
REQ-036 Accept 8'hFF + 8'h01, cin=0 -> result=8'h00 and cout=1; accept 8'h5A + 8'hA5, cin=1 -> result=8'h00 and cout=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE -> result and cout stable and out_valid high throughout; IDLE one cycle after out_ready=1.
REQ-038 Hold in_valid=1 with operands changing every cycle during RUN -> in_ready=0 and the result reflects only the captured operands.
REQ-039 Pulse rst_n=0 on RUN cycle 4 -> next cycle IDLE, in_ready=1, result=0, no out_valid; the following job 8'h10 + 8'h20 yields 8'h30.
REQ-040 Run 1000 random operand/cin jobs with random out_ready stalls -> every {cout,result} equals op_a + op_b + cin.
